// File: rtl/sbox_pkg.sv
// Shared types and constants for the s-box arbiter slice.
package sbox_pkg;

   localparam int unsigned SBOX_LATENCY_DEFAULT = 8;
   localparam int unsigned TAG_W_MAX            = 3;

   typedef struct packed {
      logic [TAG_W_MAX-1:0] tag;
      logic [7:0]           data;
   } sbox_res_t;

   function automatic int unsigned clog2_req(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sbox_result_fifo.sv
// Synchronous result FIFO; push and pop may share a cycle, written data appears the next cycle.
module sbox_result_fifo
   import sbox_pkg::*;
#(
   parameter int unsigned  Depth = 16,
   localparam int unsigned PtrW  = $clog2(Depth),
   localparam int unsigned CntW  = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  sbox_res_t       wdata_i,
   input  logic            pop_i,
   output sbox_res_t       rdata_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   sbox_res_t       mem_q [Depth];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [CntW-1:0] cnt_q;
   logic            do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CntW'(push_i) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && (cnt_q == CntW'(Depth))));

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one pipelined s-box among NUM_REQ requesters behind a credit-guarded result FIFO.
// Define SBOX_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round robin.
module sbox_arbiter
   import sbox_pkg::*;
#(
   parameter int unsigned  NUM_REQ      = 4,
   parameter int unsigned  SBOX_LATENCY = SBOX_LATENCY_DEFAULT,
   parameter int unsigned  FIFO_DEPTH   = 16,
   localparam int unsigned TagW         = clog2_req(NUM_REQ),
   localparam int unsigned UsedW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [TagW-1:0]      out_id,
   input  logic                 out_ready,
   output logic [7:0]           sbox_idata,
   output logic                 sbox_ivalid,
   output logic                 sbox_oready,
   input  logic [7:0]           sbox_odata
);

   logic                    run_q;
   logic [7:0]              sbox_idata_q;
   logic                    iss_vld_q;
   logic [TagW-1:0]         iss_tag_q;
   logic [SBOX_LATENCY-1:0] pipe_vld_q;
   logic [TagW-1:0]         pipe_tag_q [SBOX_LATENCY];
   logic                    cap_vld_q;
   logic [TagW-1:0]         cap_tag_q;
   logic [7:0]              cap_data_q;
   logic [UsedW-1:0]        used_q, used_d;
   logic                    can_issue, accept, pop;
   logic                    grant_vld;
   logic [TagW-1:0]         grant_idx, cand;
   logic [7:0]              grant_data;
   sbox_res_t               fifo_wdata, fifo_rdata;
   logic                    fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
   logic                    unused_tag;

   // Credit covers every byte between issue and pop, so the FIFO can never overflow.
   assign can_issue = run_q && (used_q < UsedW'(FIFO_DEPTH));
   assign accept    = grant_vld;
   assign pop       = out_valid && out_ready;
   assign used_d    = used_q + UsedW'(accept) - UsedW'(pop);

`ifndef SBOX_ARB_FIXED_PRIORITY_EN
   logic [TagW-1:0] rr_q, rr_d;

   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (grant_idx == TagW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rr_q <= '0;
      else        rr_q <= rr_d;
   end
`endif

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SBOX_ARB_FIXED_PRIORITY_EN
         cand = TagW'(i);
`else
         cand = TagW'((32'(rr_q) + i) % NUM_REQ);
`endif
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
      grant_vld = grant_vld && can_issue;
   end

   always_comb begin
      req_ready  = '0;
      grant_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (TagW'(i) == grant_idx) grant_data = req_data[8*i +: 8];
      end
      if (grant_vld) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q        <= 1'b0;
         sbox_idata_q <= '0;
         iss_vld_q    <= 1'b0;
         iss_tag_q    <= '0;
         pipe_vld_q   <= '0;
         cap_vld_q    <= 1'b0;
         cap_tag_q    <= '0;
         cap_data_q   <= '0;
         used_q       <= '0;
      end else begin
         run_q     <= 1'b1;
         iss_vld_q <= accept;
         if (accept) begin
            sbox_idata_q <= grant_data;
            iss_tag_q    <= grant_idx;
         end
         pipe_vld_q[0] <= iss_vld_q;
         for (int unsigned i = 1; i < SBOX_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
         cap_vld_q  <= pipe_vld_q[SBOX_LATENCY-1];
         cap_tag_q  <= pipe_tag_q[SBOX_LATENCY-1];
         cap_data_q <= sbox_odata;
         used_q     <= used_d;
      end
   end

   // Tags are qualified by the valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      pipe_tag_q[0] <= iss_tag_q;
      for (int unsigned i = 1; i < SBOX_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
   end

   always_comb begin
      fifo_wdata      = '0;
      fifo_wdata.tag  = TAG_W_MAX'(cap_tag_q);
      fifo_wdata.data = cap_data_q;
   end

   sbox_result_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (cap_vld_q),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign out_valid   = !fifo_empty;
   assign out_data    = out_valid ? fifo_rdata.data : '0;
   assign out_id      = out_valid ? fifo_rdata.tag[TagW-1:0] : '0;
   assign unused_tag  = ^fifo_rdata.tag;
   assign sbox_idata  = sbox_idata_q;
   assign sbox_ivalid = run_q;
   assign sbox_oready = run_q;

   a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      int'(fifo_cnt) <= int'(used_q));

endmodule

// File: tb/tb_sbox_arbiter.sv
// Scoreboard bench for sbox_arbiter with a behavioural affine s-box pipeline.
module tb_sbox_arbiter;

   localparam int NREQ    = 4;
   localparam int LAT     = 8;
   localparam int DEPTH   = 16;
   localparam int EXP_LAT = 10;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0] req_ready;
   logic            out_valid;
   logic [7:0]      out_data;
   logic [1:0]      out_id;
   logic            out_ready;
   logic [7:0]      sbox_idata;
   logic            sbox_ivalid;
   logic            sbox_oready;
   logic [7:0]      sbox_odata;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;
   int n_pop   = 0;
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   sbox_arbiter #(
      .NUM_REQ      (NREQ),
      .SBOX_LATENCY (LAT),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_id      (out_id),
      .out_ready   (out_ready),
      .sbox_idata  (sbox_idata),
      .sbox_ivalid (sbox_ivalid),
      .sbox_oready (sbox_oready),
      .sbox_odata  (sbox_odata)
   );

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // S-box model: input presented after edge e appears on sbox_odata after edge e+LAT.
   logic [7:0] sb_q [LAT];
   always @(posedge clk) begin
      if (sbox_ivalid && sbox_oready) begin
         sb_q[0] <= affine(sbox_idata);
         for (int i = 1; i < LAT; i++) sb_q[i] <= sb_q[i-1];
      end
   end
   assign sbox_odata = sb_q[LAT-1];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Accept tracker: every handshake pushes its expected result.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
               exp_q.push_back({2'(i), affine(req_data[8*i +: 8])});
               n_acc++;
            end
         end
      end
   end

   // Monitor: pops and compares on every output handshake.
   logic       prev_stall;
   logic [1:0] prev_id;
   logic [7:0] prev_data;
   logic [9:0] exp_item;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("hold_stable", {out_valid, out_id, out_data}, {1'b1, prev_id, prev_data});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_out: got id %0d data 0x%0h, expected no output", out_id, out_data);
            end else begin
               exp_item = exp_q.pop_front();
               check("sb_result", {out_id, out_data}, exp_item);
            end
            n_pop++;
         end
         prev_stall = out_valid && !out_ready;
         prev_id    = out_id;
         prev_data  = out_data;
      end
   end

   task automatic issue_one(input int idx, input logic [7:0] d, input logic [7:0] exp_d,
                            input string nm);
      int t;
      int lat;
      req_data[8*idx +: 8] = d;
      req_valid = '0;
      req_valid[idx] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ready[idx] && t < 50);
      check({nm, "_grant"}, 32'(req_ready), 32'(1 << idx));
      @(posedge clk);
      #1 req_valid = '0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      check({nm, "_latency"}, lat, EXP_LAT);
      check({nm, "_data"}, out_data, exp_d);
      check({nm, "_id"}, out_id, idx);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
         @(posedge clk);
         #1 t++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int t;
      int run;
      int acc0;
      int pop0;
      int cnt;
      logic [3:0] exp_rdy;
      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_sbox_idata", sbox_idata, 0);
      check("rst_sbox_ivalid", sbox_ivalid, 0);
      check("rst_sbox_oready", sbox_oready, 0);
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("run_ivalid", sbox_ivalid, 1);
      check("run_oready", sbox_oready, 1);

      issue_one(0, 8'h00, 8'h63, "req0_00");
      drain();
      issue_one(2, 8'hBB, 8'h27, "req2_bb");
      drain();
      issue_one(1, 8'h01, 8'h7C, "req1_01");
      drain();

      // Continuous requests: pointer sits at 2 after the grant to requester 1.
      req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef SBOX_ARB_FIXED_PRIORITY_EN
         exp_rdy = 4'b0001;
`else
         exp_rdy = 4'(1 << ((2 + k) % 4));
`endif
         check("rr_grant", req_ready, exp_rdy);
      end
      @(posedge clk);
      #1 req_valid = '0;
      t = 0;
      while (!out_valid && t < 30) begin
         @(posedge clk);
         #1 t++;
      end
      run = 0;
      while (out_valid && run < 20) begin
         run++;
         @(posedge clk);
         #1;
      end
      check("burst_throughput", run, 8);
      drain();

      // Backpressure: credit limits accepts to the FIFO depth.
      out_ready = 1'b0;
      acc0      = n_acc;
      req_data  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      req_valid = '1;
      repeat (40) @(negedge clk);
      check("bp_accepts", n_acc - acc0, DEPTH);
      check("bp_ready_low", req_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      pop0      = n_pop;
      out_ready = 1'b1;
      drain();
      check("bp_drained", n_pop - pop0, DEPTH);

      // Reset with five bytes in flight.
      req_data  = {8'h55, 8'h66, 8'h77, 8'h88};
      req_valid = '1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("mid_rst_req_ready", req_ready, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_id", out_id, 0);
      check("mid_rst_sbox_idata", sbox_idata, 0);
      check("mid_rst_sbox_ivalid", sbox_ivalid, 0);
      cnt = 0;
      repeat (30) begin
         @(posedge clk);
         #1 if (out_valid) cnt++;
      end
      check("no_stale", cnt, 0);
      issue_one(3, 8'h00, 8'h63, "req3_post_rst");
      drain();

      // req0 and req3 both held valid; pointer is 0 after the grant to requester 3.
      req_data  = {8'h06, 8'h00, 8'h00, 8'h05};
      req_valid = 4'b1001;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef SBOX_ARB_FIXED_PRIORITY_EN
         exp_rdy = 4'b0001;
`else
         exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
         check("pair_grant", req_ready, exp_rdy);
      end
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
